// File: rtl/query_pkg.sv
// Shared types and constants for the query patch loader.
// Pixels pack low-first into one patch word per memory row.
package query_pkg;

  localparam int DATA_WIDTH  = 11;
  localparam int PATCH_SIZE  = 5;
  localparam int ADDR_WIDTH  = 9;
  localparam int DEPTH       = 512;
  localparam int PATCH_WIDTH = DATA_WIDTH * PATCH_SIZE;
  localparam int IDX_WIDTH   = $clog2(PATCH_SIZE);

  typedef logic [PATCH_WIDTH-1:0] patch_t;
  typedef logic [DATA_WIDTH-1:0]  pixel_t;
  typedef logic [ADDR_WIDTH:0]    count_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

  function automatic count_t clamp_target(count_t n);
    return (n > count_t'(DEPTH)) ? count_t'(DEPTH) : n;
  endfunction

endpackage

// File: rtl/patch_assembler.sv
// Packs accepted pixels into a patch; flags the beat completing one.
// The patch output already includes the pixel accepted this cycle.
module patch_assembler
  import query_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [DATA_WIDTH-1:0]  pixel,
  output logic [PATCH_WIDTH-1:0] patch,
  output logic                   patch_complete
);

  logic [IDX_WIDTH-1:0] idx_q;
  logic [IDX_WIDTH-1:0] idx_d;
  patch_t               asm_q;
  patch_t               asm_d;
  logic                 last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

  always_comb begin
    last  = (idx_q == IDX_WIDTH'(PATCH_SIZE - 1));
    idx_d = idx_q;
    asm_d = asm_q;
    if (clear) begin
      idx_d = '0;
    end else if (accept) begin
      for (int k = 0; k < PATCH_SIZE; k++) begin
        if (idx_q == IDX_WIDTH'(k)) begin
          asm_d[k*DATA_WIDTH +: DATA_WIDTH] = pixel;
        end
      end
      idx_d = last ? '0 : idx_q + 1'b1;
    end
  end

  assign patch          = asm_d;
  assign patch_complete = accept && last && !clear;

endmodule

// File: rtl/query_patch_loader.sv
// Streams pixels into packed patches and writes them to port 0
// of the query patch memory, then pulses done for the search stage.
module query_patch_loader
  import query_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    num_patches,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_pixel,
  output logic                   mem_csb0,
  output logic                   mem_web0,
  output logic [ADDR_WIDTH-1:0]  mem_addr0,
  output logic [PATCH_WIDTH-1:0] mem_wpatch0,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    patch_count
);

  loader_state_t state_q;
  loader_state_t state_d;

  count_t target_q;
  count_t target_d;
  count_t count_q;
  count_t count_d;
  count_t start_target;

  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [ADDR_WIDTH-1:0] maddr_d;

  patch_t wpatch_q;
  patch_t wpatch_d;
  patch_t patch;

  logic csb_q;
  logic csb_d;
  logic web_q;
  logic web_d;

  logic job_start;
  logic accept;
  logic patch_complete;
  logic last_patch;

  assign job_start    = (state_q == IDLE) && start;
  assign start_target = clamp_target(num_patches);
  assign accept       = in_valid && in_ready;
  assign last_patch   = patch_complete
                     && ((count_q + 1'b1) == target_q);

  patch_assembler u_asm (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (job_start),
    .accept         (accept),
    .pixel          (in_pixel),
    .patch          (patch),
    .patch_complete (patch_complete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      count_q  <= '0;
      waddr_q  <= '0;
      maddr_q  <= '0;
      wpatch_q <= '0;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      waddr_q  <= waddr_d;
      maddr_q  <= maddr_d;
      wpatch_q <= wpatch_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (start_target == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (last_patch) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address counter wraps naturally at DEPTH; only reachable after
  // the final write of a full-depth job.
  always_comb begin
    target_d = target_q;
    count_d  = count_q;
    waddr_d  = waddr_q;
    maddr_d  = maddr_q;
    wpatch_d = wpatch_q;
    csb_d    = 1'b1;
    web_d    = 1'b1;
    if (job_start) begin
      target_d = start_target;
      count_d  = '0;
      waddr_d  = '0;
    end else if (patch_complete) begin
      csb_d    = 1'b0;
      web_d    = 1'b0;
      maddr_d  = waddr_q;
      wpatch_d = patch;
      waddr_d  = waddr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end
  end

  always_comb begin
    in_ready = (state_q == LOAD);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

  assign mem_csb0    = csb_q;
  assign mem_web0    = web_q;
  assign mem_addr0   = maddr_q;
  assign mem_wpatch0 = wpatch_q;
  assign patch_count = count_q;

endmodule

// File: tb/tb_query_patch_loader.sv
// Randomized bench for query_patch_loader against a queue-based
// model of the expected patch writes.
module tb_query_patch_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  num_patches = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_pixel = '0;
  logic        mem_csb0;
  logic        mem_web0;
  logic [8:0]  mem_addr0;
  logic [54:0] mem_wpatch0;
  logic        busy;
  logic        done;
  logic [9:0]  patch_count;

  query_patch_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_patches (num_patches),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pixel    (in_pixel),
    .mem_csb0    (mem_csb0),
    .mem_web0    (mem_web0),
    .mem_addr0   (mem_addr0),
    .mem_wpatch0 (mem_wpatch0),
    .busy        (busy),
    .done        (done),
    .patch_count (patch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [63:0] exp_data[$];
  int          exp_addr[$];
  int          exp_target;
  int          wr_cnt;
  int          done_cnt;
  int          first_wr_cyc;
  int          done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(string tag, logic [63:0] got,
                          logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_csb0) begin
        if (wr_cnt == 0) first_wr_cyc = cyc;
        wr_cnt++;
        if (exp_addr.size() == 0) begin
          check_eq("extra_wr", 64'd1, 64'd0);
        end else begin
          check_eq("wr_web", 64'(mem_web0), 64'd0);
          check_eq("wr_addr", 64'(mem_addr0), 64'(exp_addr.pop_front()));
          check_eq("wr_data", 64'(mem_wpatch0), exp_data.pop_front());
        end
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
        check_eq("done_pc", 64'(patch_count), 64'(exp_target));
        check_eq("done_wrs", 64'(wr_cnt), 64'(exp_target));
        check_eq("done_rdy", 64'(in_ready), 64'd0);
        check_eq("done_busy", 64'(busy), 64'd1);
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    check_eq({tag, "_rdy"}, 64'(in_ready), 64'd0);
    check_eq({tag, "_csb"}, 64'(mem_csb0), 64'd1);
    check_eq({tag, "_web"}, 64'(mem_web0), 64'd1);
    check_eq({tag, "_addr"}, 64'(mem_addr0), 64'd0);
    check_eq({tag, "_data"}, 64'(mem_wpatch0), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_pc"}, 64'(patch_count), 64'd0);
  endtask

  // base >= 0 gives pixels base, base+1, ...; otherwise random pixels.
  task automatic run_job(int n, int base, bit bursty,
                         bit restart_mid);
    logic [10:0] pix[$];
    logic [63:0] d;
    int tgt, npx, idx, t0;
    bit rdy, fin, restarted;
    tgt = (n > 512) ? 512 : n;
    npx = tgt * 5;
    for (int i = 0; i < npx; i++)
      pix.push_back(base >= 0 ? 11'(base + i) : 11'($urandom));
    for (int p = 0; p < tgt; p++) begin
      d = '0;
      for (int k = 0; k < 5; k++)
        d = d | (64'(pix[5*p + k]) << (11 * k));
      exp_data.push_back(d);
      exp_addr.push_back(p);
    end
    exp_target = tgt;
    wr_cnt = 0;
    done_cnt = 0;
    first_wr_cyc = -1;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    num_patches = 10'(n);
    t0 = cyc;
    idx = 0;
    fin = 1'b0;
    restarted = 1'b0;
    for (int c = 0; c < npx * 12 + 40 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      num_patches = 10'($urandom);
      if (done) begin
        fin = 1'b1;
        in_valid = 1'b0;
      end else begin
        rdy = in_ready;
        in_valid = (idx < npx) && (!bursty || $urandom_range(0, 2) != 0);
        in_pixel = (idx < npx) ? pix[idx] : 11'($urandom);
        if (restart_mid && !restarted && idx == 3) begin
          start = 1'b1;
          num_patches = 10'd7;
          restarted = 1'b1;
        end
        @(posedge clk);
        if (in_valid && rdy) idx++;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (!fin) check_eq("timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    check_eq("idle_rdy", 64'(in_ready), 64'd0);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_pc", 64'(patch_count), 64'(tgt));
    check_eq("done_pulses", 64'(done_cnt), 64'd1);
    check_eq("pending_wr", 64'(exp_addr.size()), 64'd0);
    if (!bursty) begin
      if (tgt == 0) begin
        check_eq("zero_done_cyc", 64'(done_cyc - t0), 64'd1);
      end else begin
        check_eq("first_wr_cyc", 64'(first_wr_cyc - t0), 64'd6);
        check_eq("done_cyc", 64'(done_cyc - t0), 64'(5 * tgt + 1));
      end
    end
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    wr_cnt = 0;
    done_cnt = 0;
    exp_target = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      in_valid = 1'($urandom);
      in_pixel = 11'($urandom);
      num_patches = 10'($urandom);
      #1;
      check_reset_outputs("rst");
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b1;

    run_job(2, 1, 1'b0, 1'b0);
    run_job(2, 1, 1'b1, 1'b0);
    run_job(3, -1, 1'b1, 1'b0);
    run_job(0, -1, 1'b0, 1'b0);
    run_job(600, -1, 1'b0, 1'b0);
    run_job(2, 1, 1'b0, 1'b1);
    run_job(4, -1, 1'b1, 1'b1);

    exp_target = 1;
    @(negedge clk);
    start = 1'b1;
    num_patches = 10'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_pixel = 11'(50 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job(1, 20, 1'b0, 1'b0);
    run_job(5, -1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/query_patch_loader.md
# query_patch_loader

Upstream feeder for the query patch memory. Accepts query-image pixels one per beat over a valid/ready stream, packs every PATCH_SIZE pixels into one DATA_WIDTH*PATCH_SIZE-bit patch, and drives the memory's port 0 (active-low csb/web) with sequential write addresses starting at 0. It loads a programmed number of patches per job, then pulses done so the search stage can start reading through port 1.

## Interface
- DATA_WIDTH, 11, bits per pixel
- PATCH_SIZE, 5, pixels per patch
- ADDR_WIDTH, 9, patch memory address width
- DEPTH, 512, patch memory depth (max patches per job)

- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle job start; sampled only in IDLE
- num_patches  in  ADDR_WIDTH+1  patches to load; sampled with start
- in_valid  in  1  pixel beat valid
- in_ready  out  1  loader can accept a pixel
- in_pixel  in  DATA_WIDTH  pixel value
- mem_csb0  out  1  memory port 0 chip select, active-low
- mem_web0  out  1  memory port 0 write enable, active-low
- mem_addr0  out  ADDR_WIDTH  write address
- mem_wpatch0  out  DATA_WIDTH*PATCH_SIZE  packed patch
- busy  out  1  job in progress (LOAD or DONE)
- done  out  1  one-cycle job-complete pulse
- patch_count  out  ADDR_WIDTH+1  patches written in current/last job

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: in_ready=0. On start, latch target = min(num_patches, DEPTH), clear pixel index, write address and patch_count. target=0 -> DONE with no write; else -> LOAD.
- LOAD: in_ready=1. A beat is accepted when in_valid && in_ready. Pixel k (0-first) of a patch goes to bits [k*DATA_WIDTH +: DATA_WIDTH]. The pixel index counts 0..PATCH_SIZE-1, then wraps.
- On accepting pixel PATCH_SIZE-1: the next cycle carries a one-cycle write strobe (mem_csb0=0, mem_web0=0, mem_addr0=current address, mem_wpatch0=completed patch). The address and patch_count increment. The assembly register is separate from the output register, so accepting the next pixel in that cycle is legal. Sustained throughput is 1 pixel/cycle.
- If the completing beat finishes patch `target`, go to DONE; in_ready is 0 from the next cycle.
- DONE: lasts one cycle, done=1 → IDLE. For a nonzero target, done coincides with the final write strobe.
- start outside IDLE is ignored. num_patches > DEPTH is clamped to DEPTH.
- Write address wraps DEPTH-1 → 0. This is reachable only after the last write of a full-DEPTH job and has no visible effect.
- Outside a write strobe: mem_csb0=1, mem_web0=1; mem_addr0 and mem_wpatch0 hold their last values.

## Timing
- Reset values: in_ready=0, mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wpatch0=0, busy=0, done=0, patch_count=0, state IDLE.
- in_ready is a function of the registered state only. There is no combinational in_valid → in_ready path.
- Write latency: strobe 1 cycle after the accept of the patch's last pixel. Data is committed at the edge ending the strobe cycle.
- patch_count updates at the same edge that raises the strobe.
- Reset asserted mid-job: all outputs return to reset values immediately. The partial patch is discarded and the job is abandoned. Memory contents already written are untouched.
- Stalls (in_valid=0) of any length in LOAD hold all state. No timeout.

## Structure
- Shared package query_pkg:
  - DATA_WIDTH, PATCH_SIZE, ADDR_WIDTH, DEPTH constants
  - patch_t packed type (DATA_WIDTH*PATCH_SIZE bits)
  - loader_state_t enum {IDLE, LOAD, DONE}
- One sub-module, patch_assembler: pixel index counter plus assembly register. It outputs patch_t with a one-cycle patch_complete flag. The top level holds the FSM, address/patch counters and the memory output registers.

## Test plan
- **Reset:** hold rst_n=0, toggle inputs -> all outputs at reset values; in_ready=0.
- **Back-to-back, 2 patches:** start with num_patches=2; pixels 1..10 on cycles 1..10 -> strobes on cycles 6 and 11.
  - First strobe: addr 0, wpatch = 1 | 2<<11 | 3<<22 | 4<<33 | 5<<44.
  - Second strobe: addr 1, pixels 6..10.
  - done=1 only on cycle 11; patch_count=2; in_ready=0 from cycle 11.
- **Bursty input:** same job with in_valid toggled randomly -> identical write sequence, values and addresses; no extra strobes.
- **Zero and oversize jobs:**
  - num_patches=0 -> done one cycle after start, no strobe, patch_count=0.
  - num_patches=600 -> exactly 512 writes, last at addr 511; patch_count=512.
- **Start while busy:** second start during LOAD -> ignored; the job completes with the original count.
- **Reset mid-patch:** assert rst_n low after 3 pixels of a num_patches=1 job, then restart with pixels 20..24 -> single write at addr 0 = 20 | 21<<11 | 22<<22 | 23<<33 | 24<<44.
